// File: rtl/mc_cmd_issuer.sv
// mc_cmd_issuer
//   Turns queued command masks into self-clearing control pulses. Each pulse
//   is held for HOLD_CYCLES and then followed by GAP_CYCLES of zero. The block
//   also snapshots the returned status word and keeps a sticky peaks-ready
//   interrupt.
//
// Ports
//   clk_control, rst_control_n : clock, async active-low reset
//   cmd_valid, cmd_mask        : command offer (written when cmd_ready)
//   cmd_ready                  : queue not full (or a pop frees a slot this cycle)
//   flush                      : synchronous queue clear
//   control                    : pulsed command word
//   busy                       : FSM not idle or queue non-empty
//   err_conflict               : run-start/run-halt conflict seen on load
//   status, snap_req           : status word and capture request
//   status_snap, snap_valid    : captured status, pulse the cycle after capture
//   peak_irq, peak_irq_ack     : sticky interrupt and its acknowledge
module mc_cmd_issuer #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk_control,
  input  logic        rst_control_n,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_mask,
  output logic        cmd_ready,
  input  logic        flush,
  output logic [31:0] control,
  output logic        busy,
  output logic        err_conflict,
  input  logic [31:0] status,
  input  logic        snap_req,
  output logic [31:0] status_snap,
  output logic        snap_valid,
  output logic        peak_irq,
  input  logic        peak_irq_ack
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]      HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]      GAP_LOAD  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] control_nxt;
  logic        err_nxt;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, wr;
  logic [31:0]   head;

  logic          st30_q;
  logic          irq_set;

  // Halt wins over start: drop bit 31 when both 31 and 28 are requested.
  function automatic logic [31:0] adjust_mask(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    if (m[31] && m[28]) r[31] = 1'b0;
    return r;
  endfunction

  function automatic logic is_conflict(input logic [31:0] m);
    return m[31] && m[28];
  endfunction

  // ---------------- command queue ----------------
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  // A flush discards the head too, so nothing is popped in a flush cycle.
  assign pop       = (state == S_IDLE) && !empty && !flush;
  assign cmd_ready = !full || pop;
  assign wr        = cmd_valid && cmd_ready && !flush;

  always_ff @(posedge clk_control or negedge rst_control_n) begin
    if (!rst_control_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    end
  end

  // Storage is data only; its contents are meaningless until written.
  always_ff @(posedge clk_control) begin
    if (wr) mem[wr_ptr] <= cmd_mask;
  end

  // ---------------- pulse FSM ----------------
  always_ff @(posedge clk_control or negedge rst_control_n) begin
    if (!rst_control_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      control      <= '0;
      err_conflict <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      control      <= control_nxt;
      err_conflict <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    control_nxt = control;
    err_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        // A zero mask is popped and dropped without leaving IDLE.
        if (pop && (head != '0)) begin
          control_nxt = adjust_mask(head);
          err_nxt     = is_conflict(head);
          cnt_nxt     = HOLD_LOAD;
          state_nxt   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          control_nxt = '0;
          cnt_nxt     = GAP_LOAD;
          state_nxt   = S_GAP;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_GAP: begin
        control_nxt = '0;
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 8'd1;
      end
      default: begin
        control_nxt = '0;
        cnt_nxt     = '0;
        state_nxt   = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE) || !empty;

  // ---------------- status snapshot and interrupt ----------------
  assign irq_set = status[31] || (status[30] && !st30_q);

  always_ff @(posedge clk_control or negedge rst_control_n) begin
    if (!rst_control_n) begin
      status_snap <= '0;
      snap_valid  <= 1'b0;
      st30_q      <= 1'b0;
      peak_irq    <= 1'b0;
    end else begin
      if (snap_req) status_snap <= status;
      snap_valid <= snap_req;
      st30_q     <= status[30];
      // Set has priority over acknowledge so a new event is never lost.
      if (irq_set)           peak_irq <= 1'b1;
      else if (peak_irq_ack) peak_irq <= 1'b0;
    end
  end

endmodule
